// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array datapath blocks.
package sa_pkg;

    localparam int unsigned SA_ADD_DATAWIDTH = 8;
    localparam int unsigned SA_NUM_COLS      = 4;

    typedef logic [SA_ADD_DATAWIDTH-1:0] psum_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } deskew_state_e;

endpackage

// File: rtl/sa_col_fifo.sv
// Single-column synchronous FIFO with a separate occupancy count.
// A push to a full FIFO is accepted only when a pop happens in the same cycle.
module sa_col_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the presented row reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/sa_output_deskew.sv
// Realigns staggered bottom-row PSUMs into complete rows and hands them to the
// result writer over valid/ready, tracking row count, last row and completion.
module sa_output_deskew
    import sa_pkg::*;
#(
    parameter int unsigned ADD_DATAWIDTH = SA_ADD_DATAWIDTH,
    parameter int unsigned NUM_COLS      = SA_NUM_COLS,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned AF_MARGIN     = 1,
    parameter int unsigned ROW_CNT_W     = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_start,
    input  logic [ROW_CNT_W-1:0]              i_num_rows,
    input  logic [NUM_COLS-1:0]               i_psum_valid,
    input  logic [NUM_COLS*ADD_DATAWIDTH-1:0] i_psum,
    output logic                              o_row_valid,
    input  logic                              i_row_ready,
    output logic [NUM_COLS*ADD_DATAWIDTH-1:0] o_row,
    output logic [ROW_CNT_W-1:0]              o_row_idx,
    output logic                              o_last,
    output logic                              o_done,
    output logic                              o_busy,
    output logic                              o_almost_full,
    output logic                              o_overflow
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AF_LEVEL = FIFO_DEPTH - AF_MARGIN;

    deskew_state_e         state_q;
    deskew_state_e         state_d;
    logic                  start_accept;
    logic                  collect;
    logic                  row_hs;
    logic                  last_hs;
    logic [NUM_COLS-1:0]   col_empty;
    logic [NUM_COLS-1:0]   col_full;
    logic [NUM_COLS-1:0]   col_af;
    logic [NUM_COLS-1:0]   col_push;
    logic [CNT_W-1:0]      col_count [NUM_COLS];
    logic [ROW_CNT_W-1:0]  row_cnt_q;
    logic [ROW_CNT_W-1:0]  last_idx_q;
    logic                  overflow_q;

    assign col_push = i_psum_valid & {NUM_COLS{collect}};

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        sa_col_fifo #(
            .DATA_W (ADD_DATAWIDTH),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (col_push[c]),
            .pop   (row_hs),
            .flush (start_accept),
            .din   (i_psum[c*ADD_DATAWIDTH +: ADD_DATAWIDTH]),
            .dout  (o_row[c*ADD_DATAWIDTH +: ADD_DATAWIDTH]),
            .empty (col_empty[c]),
            .full  (col_full[c]),
            .count (col_count[c])
        );
        assign col_af[c] = (col_count[c] >= CNT_W'(AF_LEVEL));
    end

    assign o_row_valid   = collect & ~(|col_empty);
    assign row_hs        = o_row_valid & i_row_ready;
    assign o_row_idx     = row_cnt_q;
    assign o_last        = o_row_valid & (row_cnt_q == last_idx_q);
    assign last_hs       = row_hs & o_last;
    assign o_almost_full = |col_af;
    assign o_overflow    = overflow_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = COLLECT;
            COLLECT: if (last_hs) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs and controls
    always_comb begin
        o_busy       = 1'b0;
        o_done       = 1'b0;
        start_accept = 1'b0;
        collect      = 1'b0;
        case (state_q)
            IDLE:    start_accept = i_start;
            COLLECT: begin
                o_busy  = 1'b1;
                collect = 1'b1;
            end
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    // Row bookkeeping; a zero row count collects a single row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q  <= '0;
            last_idx_q <= '0;
        end else if (start_accept) begin
            row_cnt_q  <= '0;
            last_idx_q <= (i_num_rows == '0) ? '0 : i_num_rows - ROW_CNT_W'(1);
        end else if (row_hs) begin
            row_cnt_q  <= row_cnt_q + ROW_CNT_W'(1);
        end
    end

    // Sticky overflow: a push lost to a full column with no pop that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (start_accept) begin
            overflow_q <= 1'b0;
        end else if (|(col_push & col_full & ~{NUM_COLS{row_hs}})) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sa_output_deskew.sv
// Directed bench for sa_output_deskew: stagger realignment, backpressure,
// overflow, full push+pop, reset mid-collect and edge configurations.
module tb_sa_output_deskew;

    localparam int DW = 8;
    localparam int NC = 4;
    localparam int RW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_start;
    logic [RW-1:0]   i_num_rows;
    logic [NC-1:0]   i_psum_valid;
    logic [NC*DW-1:0] i_psum;
    logic            o_row_valid;
    logic            i_row_ready;
    logic [NC*DW-1:0] o_row;
    logic [RW-1:0]   o_row_idx;
    logic            o_last;
    logic            o_done;
    logic            o_busy;
    logic            o_almost_full;
    logic            o_overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sa_output_deskew #(
        .ADD_DATAWIDTH (DW),
        .NUM_COLS      (NC),
        .FIFO_DEPTH    (4),
        .AF_MARGIN     (1),
        .ROW_CNT_W     (RW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_num_rows    (i_num_rows),
        .i_psum_valid  (i_psum_valid),
        .i_psum        (i_psum),
        .o_row_valid   (o_row_valid),
        .i_row_ready   (i_row_ready),
        .o_row         (o_row),
        .o_row_idx     (o_row_idx),
        .o_last        (o_last),
        .o_done        (o_done),
        .o_busy        (o_busy),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow)
    );

    function automatic logic [NC*DW-1:0] exp_row(input int m);
        logic [NC*DW-1:0] r;
        for (int c = 0; c < NC; c++) r[c*DW +: DW] = DW'(10*m + c);
        return r;
    endfunction

    task automatic zero_inputs();
        i_start = 1'b0; i_num_rows = '0; i_psum_valid = '0; i_psum = '0; i_row_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        zero_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int n);
        i_start = 1'b1;
        i_num_rows = RW'(n);
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // Column c carries 10*m+c for row m during cycle m+c after collection starts.
    task automatic drive_stagger(input int k, input int rows);
        i_psum_valid = '0;
        i_psum = '0;
        for (int c = 0; c < NC; c++) begin
            if (k - c >= 0 && k - c < rows) begin
                i_psum_valid[c] = 1'b1;
                i_psum[c*DW +: DW] = DW'(10*(k - c) + c);
            end
        end
    endtask

    // Stagger stimulus with ready low until ready_from, checked against a row/occupancy model.
    task automatic run_stagger(input int rows, input int ready_from, input string tag);
        int er, done_k, pushed;
        logic ev, eaf, ebusy;
        er = 0;
        done_k = -1;
        for (int k = 0; k < ready_from + rows + NC + 3; k++) begin
            drive_stagger(k, rows);
            i_row_ready = (k >= ready_from);
            @(negedge clk);
            ev = (er < rows) && (k >= er + NC);
            ebusy = (done_k < 0) || (k < done_k);
            eaf = 1'b0;
            for (int c = 0; c < NC; c++) begin
                pushed = k - c;
                if (pushed < 0) pushed = 0;
                if (pushed > rows) pushed = rows;
                if (pushed - er >= 3) eaf = 1'b1;
            end
            total++;
            if (o_row_valid !== ev) begin
                bad++; $display("FAIL %s valid k=%0d got %b exp %b", tag, k, o_row_valid, ev);
            end
            if (ev) begin
                total++;
                if (o_row !== exp_row(er) || o_row_idx !== RW'(er) || o_last !== (er == rows - 1)) begin
                    bad++;
                    $display("FAIL %s row k=%0d got %h/%0d/%b exp %h/%0d/%b", tag, k,
                             o_row, o_row_idx, o_last, exp_row(er), er, (er == rows - 1));
                end
            end
            total++;
            if (o_done !== (k == done_k) || o_busy !== ebusy) begin
                bad++; $display("FAIL %s done/busy k=%0d got %b/%b exp %b/%b", tag, k,
                                o_done, o_busy, (k == done_k), ebusy);
            end
            total++;
            if (o_almost_full !== eaf || o_overflow !== 1'b0) begin
                bad++; $display("FAIL %s af/ovf k=%0d got %b/%b exp %b/0", tag, k,
                                o_almost_full, o_overflow, eaf);
            end
            if (ev && k >= ready_from) begin
                er++;
                if (er == rows) done_k = k + 1;
            end
            @(posedge clk); #1;
        end
        zero_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        zero_inputs();
        @(negedge clk);
        total++;
        if ({o_row_valid, o_row, o_row_idx, o_last, o_done, o_busy, o_almost_full, o_overflow} !== '0) begin
            bad++; $display("FAIL reset outputs got %b%h%h%b%b%b%b%b exp all 0", o_row_valid, o_row,
                            o_row_idx, o_last, o_done, o_busy, o_almost_full, o_overflow);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        // Pushes in IDLE must be ignored without error
        i_psum_valid = '1; i_psum = exp_row(9);
        @(posedge clk); #1;
        zero_inputs();
        @(negedge clk);
        total++;
        if (o_overflow !== 1'b0 || o_almost_full !== 1'b0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL idle_push got ovf=%b af=%b busy=%b exp 0/0/0", o_overflow, o_almost_full, o_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ideal();
        apply_reset();
        do_start(4);
        run_stagger(4, 0, "ideal");
    endtask

    task automatic test_backpressure();
        apply_reset();
        do_start(4);
        run_stagger(4, 12, "backpressure");
    endtask

    task automatic test_overflow();
        apply_reset();
        do_start(6);
        for (int k = 0; k < 9; k++) begin
            drive_stagger(k, 6);
            @(negedge clk);
            if (k == 4 || k == 5) begin
                total++;
                if (o_overflow !== 1'(k == 5)) begin
                    bad++; $display("FAIL ovf_set k=%0d got %b exp %b", k, o_overflow, (k == 5));
                end
            end
            @(posedge clk); #1;
        end
        i_psum_valid = '0; i_psum = '0; i_row_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            total++;
            if (o_row_valid !== 1'b1 || o_row !== exp_row(m) || o_overflow !== 1'b1) begin
                bad++; $display("FAIL ovf_drain m=%0d got v=%b %h ovf=%b exp v=1 %h ovf=1", m,
                                o_row_valid, o_row, o_overflow, exp_row(m));
            end
            @(posedge clk); #1;
        end
        i_psum_valid = '1; i_psum = exp_row(4);
        @(negedge clk);
        total++;
        if (o_row_valid !== 1'b0) begin
            bad++; $display("FAIL ovf_empty got %b exp 0", o_row_valid);
        end
        @(posedge clk); #1;
        i_psum = exp_row(5);
        @(negedge clk);
        total++;
        if (o_row_valid !== 1'b1 || o_row !== exp_row(4) || o_row_idx !== RW'(4) || o_last !== 1'b0) begin
            bad++; $display("FAIL ovf_row4 got %b %h %0d %b exp 1 %h 4 0", o_row_valid, o_row, o_row_idx, o_last, exp_row(4));
        end
        @(posedge clk); #1;
        i_psum_valid = '0; i_psum = '0;
        @(negedge clk);
        total++;
        if (o_row_valid !== 1'b1 || o_row !== exp_row(5) || o_row_idx !== RW'(5) || o_last !== 1'b1) begin
            bad++; $display("FAIL ovf_row5 got %b %h %0d %b exp 1 %h 5 1", o_row_valid, o_row, o_row_idx, o_last, exp_row(5));
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (o_done !== 1'b1 || o_overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_done got done=%b ovf=%b exp 1/1", o_done, o_overflow);
        end
        @(posedge clk); #1;
        i_row_ready = 1'b0;
        do_start(3);
        @(negedge clk);
        total++;
        if (o_overflow !== 1'b0 || o_busy !== 1'b1) begin
            bad++; $display("FAIL ovf_clear got ovf=%b busy=%b exp 0/1", o_overflow, o_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        do_start(5);
        i_psum_valid = '1; i_psum = exp_row(0);
        @(posedge clk); #1;
        for (int m = 1; m < 4; m++) begin
            i_psum_valid = 4'b0001; i_psum = exp_row(m);
            @(posedge clk); #1;
        end
        // Column 0 is full; pop and push it in the same cycle
        i_row_ready = 1'b1; i_psum_valid = 4'b0001; i_psum = exp_row(4);
        @(negedge clk);
        total++;
        if (o_row_valid !== 1'b1 || o_row !== exp_row(0) || o_almost_full !== 1'b1) begin
            bad++; $display("FAIL fpp_row0 got v=%b %h af=%b exp v=1 %h af=1", o_row_valid, o_row, o_almost_full, exp_row(0));
        end
        @(posedge clk); #1;
        i_row_ready = 1'b0;
        for (int m = 1; m < 5; m++) begin
            i_psum_valid = 4'b1110; i_psum = exp_row(m);
            @(negedge clk);
            if (m == 1) begin
                total++;
                if (o_overflow !== 1'b0 || o_almost_full !== 1'b1 || o_row_valid !== 1'b0) begin
                    bad++; $display("FAIL fpp_after got ovf=%b af=%b v=%b exp 0/1/0", o_overflow, o_almost_full, o_row_valid);
                end
            end
            if (m == 2) begin
                total++;
                if (o_row_valid !== 1'b1 || o_row !== exp_row(1)) begin
                    bad++; $display("FAIL fpp_row1_early got v=%b %h exp v=1 %h", o_row_valid, o_row, exp_row(1));
                end
            end
            @(posedge clk); #1;
        end
        i_psum_valid = '0; i_psum = '0; i_row_ready = 1'b1;
        for (int m = 1; m < 5; m++) begin
            @(negedge clk);
            total++;
            if (o_row_valid !== 1'b1 || o_row !== exp_row(m) || o_row_idx !== RW'(m) || o_last !== (m == 4)) begin
                bad++; $display("FAIL fpp_drain m=%0d got %b %h %0d %b exp 1 %h %0d %b", m, o_row_valid, o_row,
                                o_row_idx, o_last, exp_row(m), m, (m == 4));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (o_done !== 1'b1 || o_overflow !== 1'b0) begin
            bad++; $display("FAIL fpp_done got done=%b ovf=%b exp 1/0", o_done, o_overflow);
        end
        @(posedge clk); #1;
        zero_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        i_row_ready = 1'b1;
        do_start(4);
        for (int k = 0; k < 6; k++) begin
            drive_stagger(k, 4);
            @(negedge clk);
            if (k == 5) begin
                total++;
                if (o_row_valid !== 1'b1 || o_row_idx !== RW'(1)) begin
                    bad++; $display("FAIL rst_mid_pre got v=%b idx=%0d exp 1/1", o_row_valid, o_row_idx);
                end
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        i_psum_valid = '0; i_psum = '0;
        @(negedge clk);
        total++;
        if ({o_row_valid, o_row, o_row_idx, o_last, o_done, o_busy, o_almost_full, o_overflow} !== '0) begin
            bad++; $display("FAIL rst_mid outputs got v=%b %h idx=%0d l=%b d=%b b=%b af=%b ovf=%b exp all 0",
                            o_row_valid, o_row, o_row_idx, o_last, o_done, o_busy, o_almost_full, o_overflow);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                bad++; $display("FAIL rst_mid_quiet k=%0d got done=%b busy=%b exp 0/0", k, o_done, o_busy);
            end
            @(posedge clk); #1;
        end
        do_start(2);
        run_stagger(2, 0, "rst_restart");
    endtask

    task automatic test_edge_config();
        apply_reset();
        do_start(0);
        // Second start while collecting must not re-arm or flush
        i_psum_valid = '1; i_psum = exp_row(7); i_start = 1'b1; i_num_rows = RW'(5);
        @(posedge clk); #1;
        i_start = 1'b0; i_psum_valid = '0; i_psum = '0; i_row_ready = 1'b1;
        @(negedge clk);
        total++;
        if (o_row_valid !== 1'b1 || o_row !== exp_row(7) || o_row_idx !== RW'(0) || o_last !== 1'b1) begin
            bad++; $display("FAIL edge_row got %b %h %0d %b exp 1 %h 0 1", o_row_valid, o_row, o_row_idx, o_last, exp_row(7));
        end
        @(posedge clk); #1;
        i_row_ready = 1'b0;
        @(negedge clk);
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            bad++; $display("FAIL edge_done got done=%b busy=%b exp 1/0", o_done, o_busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_row_valid !== 1'b0) begin
            bad++; $display("FAIL edge_idle got done=%b busy=%b v=%b exp 0/0/0", o_done, o_busy, o_row_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_edge_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
